// File: rtl/sw_leds_demux_pkg.sv
// Shared types and default widths for the X/Y nibble demultiplexer.
package sw_leds_demux_pkg;

  // Reassembly FSM: waiting for X, waiting for Y, holding a complete pair.
  typedef enum logic [1:0] {
    EXP_X = 2'd0,
    EXP_Y = 2'd1,
    FULL  = 2'd2
  } state_e;

  localparam int DEF_DATA_W = 4;
  localparam int DEF_ERR_W  = 4;
  localparam int DEF_CNT_W  = 8;

endpackage

// File: rtl/sw_leds_demux_sat_counter.sv
// Saturating up-counter: counts inc pulses and sticks at all-ones.
module sat_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  // Increment on inc unless already at the maximum value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_count <= '0;
    else if (inc && (r_count != {WIDTH{1'b1}}))
      r_count <= r_count + {{(WIDTH-1){1'b0}}, 1'b1};
  end

  assign count = r_count;

endmodule

// File: rtl/sw_leds_demux.sv
// Reassembles X/Y operands from a time-multiplexed nibble stream into a
// registered pair with valid/ready handshake, plus sequence-error and pair
// counters.
module sw_leds_demux
  import sw_leds_demux_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ERR_W  = DEF_ERR_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              CLOCK_50,
  input  logic              RESET,
  input  logic [DATA_W-1:0] mux_data,
  input  logic              mux_sel,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] x_out,
  output logic [DATA_W-1:0] y_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              seq_err,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  pair_cnt
);

  state_e            r_state;
  logic [DATA_W-1:0] r_x;
  logic [DATA_W-1:0] r_y;
  logic              r_out_valid;
  logic              r_seq_err;
  logic [CNT_W-1:0]  r_pair_cnt;

  logic w_accept;
  logic w_viol;

  // Ready is a pure state decode so it never combinationally depends on inputs.
  assign in_ready = (r_state != FULL);
  assign w_accept = in_valid & in_ready;

  // A Y while waiting for X, or an X while waiting for Y, breaks the sequence.
  assign w_viol = w_accept &&
                  (((r_state == EXP_X) &&  mux_sel) ||
                   ((r_state == EXP_Y) && !mux_sel));

  // FSM, operand registers, pair counter and registered error pulse.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      r_state     <= EXP_X;
      r_x         <= '0;
      r_y         <= '0;
      r_out_valid <= 1'b0;
      r_seq_err   <= 1'b0;
      r_pair_cnt  <= '0;
    end else begin
      r_seq_err <= w_viol;
      case (r_state)
        EXP_X: begin
          // A stray Y is dropped; only the error pulse/counter see it.
          if (w_accept && !mux_sel) begin
            r_x     <= mux_data;
            r_state <= EXP_Y;
          end
        end
        EXP_Y: begin
          if (w_accept) begin
            if (mux_sel) begin
              r_y         <= mux_data;
              r_out_valid <= 1'b1;
              r_state     <= FULL;
            end else begin
              // A repeated X resynchronises on the newest X value.
              r_x <= mux_data;
            end
          end
        end
        FULL: begin
          // Hold the pair until downstream takes it; inputs are not accepted.
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_pair_cnt  <= r_pair_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            r_state     <= EXP_X;
          end
        end
        default: r_state <= EXP_X;
      endcase
    end
  end

  sat_counter #(
    .WIDTH (ERR_W)
  ) u_err_cnt (
    .clk   (CLOCK_50),
    .reset (RESET),
    .inc   (w_viol),
    .count (err_cnt)
  );

  assign x_out     = r_x;
  assign y_out     = r_y;
  assign out_valid = r_out_valid;
  assign seq_err   = r_seq_err;
  assign pair_cnt  = r_pair_cnt;

endmodule

// File: tb/tb_sw_leds_demux.sv
// Self-checking bench for sw_leds_demux: reference model plus pair scoreboard.
module tb_sw_leds_demux;

  logic       CLOCK_50 = 1'b0;
  logic       RESET;
  logic [3:0] mux_data;
  logic       mux_sel;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] x_out;
  logic [3:0] y_out;
  logic       out_valid;
  logic       out_ready;
  logic       seq_err;
  logic [3:0] err_cnt;
  logic [7:0] pair_cnt;

  sw_leds_demux #(.DATA_W(4), .ERR_W(4), .CNT_W(8)) dut (
    .CLOCK_50  (CLOCK_50),
    .RESET     (RESET),
    .mux_data  (mux_data),
    .mux_sel   (mux_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_out     (x_out),
    .y_out     (y_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .seq_err   (seq_err),
    .err_cnt   (err_cnt),
    .pair_cnt  (pair_cnt)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic [3:0] x;
    logic [3:0] y;
  } pair_t;

  pair_t sbq[$];
  int    n_vec = 0;
  int    n_bad = 0;

  // reference model (0=EXP_X, 1=EXP_Y, 2=FULL)
  int         m_st;
  logic [3:0] m_x;
  int         m_err;
  int         m_pairs;

  task automatic model_reset();
    m_st = 0; m_x = 4'h0; m_err = 0; m_pairs = 0;
    sbq.delete();
  endtask

  // Drive one cycle of inputs, advance the model, sample #1 after the edge.
  task automatic cyc(input logic v, input logic s, input logic [3:0] d, input logic r);
    in_valid = v; mux_sel = s; mux_data = d; out_ready = r;
    if (m_st != 2 && v) begin
      if (m_st == 0) begin
        if (!s) begin m_x = d; m_st = 1; end
        else if (m_err < 15) m_err++;
      end else begin
        if (s) begin
          sbq.push_back('{x: m_x, y: d});
          m_st = 2;
        end else begin
          m_x = d;
          if (m_err < 15) m_err++;
        end
      end
    end else if (m_st == 2 && r) begin
      m_st = 0;
      m_pairs = (m_pairs + 1) % 256;
    end
    @(posedge CLOCK_50); #1;
  endtask

  task automatic test_reset();
    RESET = 1'b1; in_valid = 0; mux_sel = 0; mux_data = 0; out_ready = 0;
    model_reset();
    #1;
    n_vec++; if (x_out !== 4'h0)     begin n_bad++; $display("FAIL reset_x got=%h exp=0", x_out); end
    n_vec++; if (y_out !== 4'h0)     begin n_bad++; $display("FAIL reset_y got=%h exp=0", y_out); end
    n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_ov got=%b exp=0", out_valid); end
    n_vec++; if (seq_err !== 1'b0)   begin n_bad++; $display("FAIL reset_se got=%b exp=0", seq_err); end
    n_vec++; if (err_cnt !== 4'h0)   begin n_bad++; $display("FAIL reset_ec got=%h exp=0", err_cnt); end
    n_vec++; if (pair_cnt !== 8'h0)  begin n_bad++; $display("FAIL reset_pc got=%h exp=0", pair_cnt); end
    n_vec++; if (in_ready !== 1'b1)  begin n_bad++; $display("FAIL reset_rdy got=%b exp=1", in_ready); end
    @(posedge CLOCK_50); #1;
    RESET = 1'b0;
  endtask

  task automatic test_basic_pair();
    pair_t p;
    cyc(1, 0, 4'h5, 1);
    n_vec++; if (x_out !== 4'h5)     begin n_bad++; $display("FAIL basic_x got=%h exp=5", x_out); end
    n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_ov0 got=%b exp=0", out_valid); end
    cyc(1, 1, 4'hA, 1);
    n_vec++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL basic_ov1 got=%b exp=1", out_valid); end
    n_vec++; if (in_ready !== 1'b0)  begin n_bad++; $display("FAIL basic_rdy got=%b exp=0", in_ready); end
    n_vec++;
    if (sbq.size() == 0) begin n_bad++; $display("FAIL basic_sb got=empty exp=pair"); end
    else begin
      p = sbq.pop_front();
      if (x_out !== p.x || y_out !== p.y) begin
        n_bad++; $display("FAIL basic_pair got=%h/%h exp=%h/%h", x_out, y_out, p.x, p.y);
      end
    end
    cyc(0, 0, 4'h0, 1);
    n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_ov2 got=%b exp=0", out_valid); end
    n_vec++; if (pair_cnt !== 8'd1)  begin n_bad++; $display("FAIL basic_pc got=%0d exp=1", pair_cnt); end
  endtask

  task automatic test_seq_err();
    cyc(1, 1, 4'h3, 0);
    n_vec++; if (seq_err !== 1'b1)  begin n_bad++; $display("FAIL seqerr_pulse got=%b exp=1", seq_err); end
    n_vec++; if (err_cnt !== 4'd1)  begin n_bad++; $display("FAIL seqerr_cnt got=%0d exp=1", err_cnt); end
    n_vec++; if (x_out !== 4'h5)    begin n_bad++; $display("FAIL seqerr_x got=%h exp=5", x_out); end
    n_vec++; if (y_out !== 4'hA)    begin n_bad++; $display("FAIL seqerr_y got=%h exp=a", y_out); end
    cyc(0, 0, 4'h0, 0);
    n_vec++; if (seq_err !== 1'b0)  begin n_bad++; $display("FAIL seqerr_width got=%b exp=0", seq_err); end
  endtask

  task automatic test_resync();
    pair_t p;
    cyc(1, 0, 4'h1, 0);
    n_vec++; if (seq_err !== 1'b0) begin n_bad++; $display("FAIL resync_noerr got=%b exp=0", seq_err); end
    cyc(1, 0, 4'h7, 0);
    n_vec++; if (seq_err !== 1'b1) begin n_bad++; $display("FAIL resync_err got=%b exp=1", seq_err); end
    n_vec++; if (err_cnt !== 4'd2) begin n_bad++; $display("FAIL resync_cnt got=%0d exp=2", err_cnt); end
    n_vec++; if (x_out !== 4'h7)   begin n_bad++; $display("FAIL resync_x got=%h exp=7", x_out); end
    cyc(1, 1, 4'h2, 0);
    n_vec++; if (seq_err !== 1'b0 || out_valid !== 1'b1) begin
      n_bad++; $display("FAIL resync_done got=se%b/ov%b exp=se0/ov1", seq_err, out_valid);
    end
    n_vec++;
    if (sbq.size() == 0) begin n_bad++; $display("FAIL resync_sb got=empty exp=pair"); end
    else begin
      p = sbq.pop_front();
      if (x_out !== p.x || y_out !== p.y || p.x !== 4'h7 || p.y !== 4'h2) begin
        n_bad++; $display("FAIL resync_pair got=%h/%h exp=7/2", x_out, y_out);
      end
    end
  endtask

  // Enters with a pair (7,2) held in FULL.
  task automatic test_hold();
    for (int i = 0; i < 5; i++) begin
      cyc(1, i[0], 4'(i + 8), 0);
      n_vec++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || x_out !== 4'h7 || y_out !== 4'h2 || seq_err !== 1'b0) begin
        n_bad++;
        $display("FAIL hold_%0d got=rdy%b ov%b x%h y%h se%b exp=rdy0 ov1 x7 y2 se0",
                 i, in_ready, out_valid, x_out, y_out, seq_err);
      end
    end
    cyc(0, 0, 4'h0, 1);
    n_vec++; if (out_valid !== 1'b0 || pair_cnt !== 8'd2) begin
      n_bad++; $display("FAIL hold_release got=ov%b pc%0d exp=ov0 pc2", out_valid, pair_cnt);
    end
  endtask

  // Continuous in_valid at max rate: X, Y, then a FULL cycle whose X must be ignored.
  task automatic test_back_to_back(input int npairs, input bool_chk);
    pair_t      p;
    logic [3:0] x, y;
    for (int i = 0; i < npairs; i++) begin
      x = 4'($urandom_range(0, 15));
      y = 4'($urandom_range(0, 15));
      cyc(1, 0, x, 1);
      if (bool_chk) begin
        n_vec++; if (x_out !== x || out_valid !== 1'b0) begin
          n_bad++; $display("FAIL b2b_x%0d got=%h/ov%b exp=%h/ov0", i, x_out, out_valid, x);
        end
      end
      cyc(1, 1, y, 1);
      n_vec++;
      if (out_valid !== 1'b1 || sbq.size() == 0) begin
        n_bad++; $display("FAIL b2b_ov%0d got=ov%b sb%0d exp=ov1 sb>0", i, out_valid, sbq.size());
        sbq.delete();
      end else begin
        p = sbq.pop_front();
        if (x_out !== p.x || y_out !== p.y) begin
          n_bad++; $display("FAIL b2b_pair%0d got=%h/%h exp=%h/%h", i, x_out, y_out, p.x, p.y);
        end
      end
      cyc(1, 0, ~x, 1);
      if (bool_chk) begin
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || x_out !== x || pair_cnt !== 8'(m_pairs)) begin
          n_bad++;
          $display("FAIL b2b_drain%0d got=ov%b rdy%b x%h pc%0d exp=ov0 rdy1 x%h pc%0d",
                   i, out_valid, in_ready, x_out, pair_cnt, x, m_pairs);
        end
      end
    end
  endtask

  task automatic test_err_sat();
    for (int i = 0; i < 16; i++) begin
      cyc(1, 1, 4'(i), 0);
      n_vec++; if (seq_err !== 1'b1 || err_cnt !== 4'(m_err)) begin
        n_bad++; $display("FAIL sat_%0d got=se%b ec%0d exp=se1 ec%0d", i, seq_err, err_cnt, m_err);
      end
    end
    n_vec++; if (err_cnt !== 4'd15) begin n_bad++; $display("FAIL sat_final got=%0d exp=15", err_cnt); end
  endtask

  task automatic test_pair_wrap();
    test_back_to_back(256 - m_pairs, 1'b0);
    n_vec++; if (pair_cnt !== 8'd0) begin n_bad++; $display("FAIL wrap_pc got=%0d exp=0", pair_cnt); end
  endtask

  task automatic test_reset_mid();
    // reset while waiting for Y
    cyc(1, 0, 4'h9, 0);
    n_vec++; if (x_out !== 4'h9) begin n_bad++; $display("FAIL rmid_x got=%h exp=9", x_out); end
    RESET = 1'b1; model_reset(); #1;
    n_vec++; if (x_out !== 4'h0 || y_out !== 4'h0 || out_valid !== 1'b0 || seq_err !== 1'b0 ||
                 err_cnt !== 4'h0 || pair_cnt !== 8'h0 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL rmid_async got=x%h y%h ov%b se%b ec%0d pc%0d rdy%b exp=all0 rdy1",
                        x_out, y_out, out_valid, seq_err, err_cnt, pair_cnt, in_ready);
    end
    RESET = 1'b0;
    cyc(1, 1, 4'h4, 0);
    n_vec++; if (seq_err !== 1'b1 || err_cnt !== 4'd1 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL rmid_y got=se%b ec%0d ov%b exp=se1 ec1 ov0", seq_err, err_cnt, out_valid);
    end
    // reset while a pair is held
    cyc(1, 0, 4'hC, 0);
    cyc(1, 1, 4'hD, 0);
    n_vec++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL rfull_ov got=%b exp=1", out_valid); end
    RESET = 1'b1; model_reset(); #1;
    RESET = 1'b0;
    cyc(0, 0, 4'h0, 1);
    n_vec++; if (out_valid !== 1'b0 || pair_cnt !== 8'd0 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL rfull_drop got=ov%b pc%0d rdy%b exp=ov0 pc0 rdy1", out_valid, pair_cnt, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_basic_pair();
    test_seq_err();
    test_resync();
    test_hold();
    test_back_to_back(4, 1'b1);
    test_err_sat();
    test_pair_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
